// File: rtl/line_fifo_sched_pkg.sv
// Shared types and sizing helpers for the line-buffer FIFO read scheduler.
package line_fifo_sched_pkg;

    localparam int unsigned DEF_DW   = 16;
    localparam int unsigned DEF_N_CH = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_fifo_rr_scheduler_rr_pick.sv
// Rotate-priority picker: first requester strictly after last_gnt, wrapping upward.
module rr_pick #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CHW  = 2
) (
    input  logic [N_CH-1:0] req,
    input  logic [CHW-1:0]  last_gnt,
    output logic [CHW-1:0]  gnt,
    output logic            any_req
);

    logic [CHW-1:0] idx;

    // Scan farthest-first so the nearest requester after last_gnt overwrites.
    always_comb begin
        gnt = last_gnt;
        idx = '0;
        for (int unsigned k = N_CH; k > 0; k--) begin
            idx = CHW'((32'(last_gnt) + k) % N_CH);
            if (req[idx]) begin
                gnt = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/line_fifo_rr_scheduler.sv
// Round-robin burst scheduler draining N_CH prefetch FIFOs onto one registered stream.
module line_fifo_rr_scheduler
    import line_fifo_sched_pkg::*;
#(
    parameter int unsigned  N_CH    = DEF_N_CH,
    parameter int unsigned  DW      = DEF_DW,
    parameter int unsigned  BURST   = 16,
    parameter int unsigned  IDLE_TO = 8,
    localparam int unsigned CHW     = idx_width(N_CH),
    localparam int unsigned BCW     = idx_width(BURST)
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    input  logic               en,
    input  logic [N_CH-1:0]    ch_mask,
    input  logic [N_CH-1:0]    fifo_rd_vld,
    input  logic [N_CH*DW-1:0] fifo_rd_data,
    output logic [N_CH-1:0]    fifo_rd_en,
    output logic [DW-1:0]      out_data,
    output logic [CHW-1:0]     out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               burst_abort,
    output logic               busy
);

    localparam int unsigned TOW = idx_width(IDLE_TO);

    state_t         state, state_nxt;
    logic [CHW-1:0] gnt, last_gnt, pick;
    logic [BCW-1:0] beat_cnt;
    logic [TOW-1:0] to_cnt;
    logic [N_CH-1:0] req;
    logic           any_req, gnt_vld;
    logic           start, pop, beat_end, starve_end;

    assign req     = fifo_rd_vld & ch_mask;
    assign gnt_vld = fifo_rd_vld[gnt];
    assign busy    = (state == S_BURST);

    rr_pick #(
        .N_CH (N_CH),
        .CHW  (CHW)
    ) u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .gnt      (pick),
        .any_req  (any_req)
    );

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pop strobe and burst termination; pop is combinational to the FIFOs.
    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        pop        = 1'b0;
        beat_end   = 1'b0;
        starve_end = 1'b0;
        fifo_rd_en = '0;
        case (state)
            S_IDLE: begin
                if (en && any_req) begin
                    start     = 1'b1;
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                pop             = gnt_vld && (!out_valid || out_ready);
                fifo_rd_en[gnt] = pop;
                beat_end        = pop && (beat_cnt == BCW'(BURST - 1));
                starve_end      = !gnt_vld && (to_cnt == TOW'(IDLE_TO - 1));
                if (beat_end || starve_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, beat and starvation counters; backpressure with data present is not starvation.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            gnt      <= '0;
            last_gnt <= CHW'(N_CH - 1);
            beat_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (start) begin
                gnt      <= pick;
                beat_cnt <= '0;
                to_cnt   <= '0;
            end
            if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == S_BURST) begin
                if (gnt_vld) begin
                    to_cnt <= '0;
                end else if (!starve_end) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
            if (beat_end || starve_end) begin
                last_gnt <= gnt;
            end
        end
    end

    // Output stage: a held beat survives the end of its burst until accepted.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            out_last    <= 1'b0;
            burst_abort <= 1'b0;
        end else begin
            burst_abort <= starve_end;
            if (pop) begin
                out_valid <= 1'b1;
                out_data  <= fifo_rd_data[DW*32'(gnt) +: DW];
                out_ch    <= gnt;
                out_last  <= beat_end;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_fifo_rr_scheduler.sv
// Directed bench: FIFO bank model, stream capture, and table-driven expected beat lists.
module tb_line_fifo_rr_scheduler;

    localparam int unsigned N_CH    = 4;
    localparam int unsigned DW      = 16;
    localparam int unsigned BURST   = 4;
    localparam int unsigned IDLE_TO = 8;
    localparam int unsigned CHW     = 2;
    localparam int unsigned DEPTH   = 64;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  data;
        logic           last;
    } beat_t;

    typedef struct {
        beat_t beat;
        int    cyc;
    } cap_t;

    typedef struct {
        int   ch;
        int   word;
        logic last;
    } vec_t;

    logic               rd_clk = 1'b0;
    logic               rd_rst;
    logic               en;
    logic [N_CH-1:0]    ch_mask;
    logic [N_CH-1:0]    fifo_rd_vld;
    logic [N_CH*DW-1:0] fifo_rd_data;
    logic [N_CH-1:0]    fifo_rd_en;
    logic [DW-1:0]      out_data;
    logic [CHW-1:0]     out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               burst_abort;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    line_fifo_rr_scheduler #(
        .N_CH    (N_CH),
        .DW      (DW),
        .BURST   (BURST),
        .IDLE_TO (IDLE_TO)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .en           (en),
        .ch_mask      (ch_mask),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .burst_abort  (burst_abort),
        .busy         (busy)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO bank model: show-ahead, pops on fifo_rd_en, pointers reset with rd_rst.
    logic [DW-1:0] mem [N_CH][DEPTH];
    int wr_cnt [N_CH];
    int rd_ptr [N_CH];

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < N_CH; i++) rd_ptr[i] <= 0;
        end else begin
            for (int i = 0; i < N_CH; i++) if (fifo_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            fifo_rd_vld[i]            = rd_ptr[i] < wr_cnt[i];
            fifo_rd_data[i*DW +: DW] = mem[i][rd_ptr[i] % DEPTH];
        end
    end

    // Stream monitor: records accepted beats, abort pulses and pop-rule violations.
    cap_t cap[$];
    int   cyc       = 0;
    int   abort_cnt = 0;
    int   abort_cyc = 0;
    int   en_viol   = 0;

    always @(negedge rd_clk) begin
        cap_t c;
        cyc++;
        if (out_valid && out_ready) begin
            c.beat = {out_ch, out_data, out_last};
            c.cyc  = cyc;
            cap.push_back(c);
        end
        if (burst_abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if ((fifo_rd_en != '0) && out_valid && !out_ready) en_viol++;
        if ($countones(fifo_rd_en) > 1) en_viol++;
    end

    function automatic logic [DW-1:0] wd(input int ch, input int n);
        return DW'(ch * 4096 + n);
    endfunction

    function automatic int exp_of(input vec_t v);
        beat_t b;
        b.ch   = CHW'(v.ch);
        b.data = wd(v.ch, v.word);
        b.last = v.last;
        return int'(b);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge rd_clk);
        #1;
    endtask

    task automatic fill(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_cnt[ch] % DEPTH] = wd(ch, wr_cnt[ch]);
            wr_cnt[ch]++;
        end
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        en     = 1'b0;
        for (int i = 0; i < N_CH; i++) wr_cnt[i] = 0;
        tick();
        tick();
        rd_rst = 1'b0;
        tick();
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            sample();
            k++;
        end
    endtask

    task automatic compare_tab(input string name, input int base, input vec_t tab[$]);
        int got;
        check({name, "_count"}, cap.size() - base, tab.size());
        for (int i = 0; i < tab.size(); i++) begin
            got = (base + i < cap.size()) ? int'(cap[base + i].beat) : -1;
            check($sformatf("%s_beat%0d", name, i), got, exp_of(tab[i]));
        end
    endtask

    function automatic int cyc_at(input int idx);
        return (idx < cap.size()) ? cap[idx].cyc : -1000;
    endfunction

    initial begin
        vec_t tab_a[$];
        vec_t tab_b[$];
        vec_t tab_c[$];
        vec_t tab_d[$];
        int   base;
        int   ab0;
        int   viol0;
        logic [N_CH-1:0] seen_en;
        logic seen_busy;

        // Expected beat tables: {channel, word index since reset, out_last}.
        tab_a = '{'{0,0,0}, '{0,1,0}, '{0,2,0}, '{0,3,1},
                  '{0,4,0}, '{0,5,0}, '{0,6,0}, '{0,7,1},
                  '{0,8,0}, '{0,9,0}};
        tab_b = '{'{0,0,0}, '{0,1,0}, '{0,2,0}, '{0,3,1},
                  '{1,0,0}, '{1,1,0}, '{1,2,0}, '{1,3,1},
                  '{2,0,0}, '{2,1,0}, '{2,2,0}, '{2,3,1},
                  '{3,0,0}, '{3,1,0}, '{3,2,0}, '{3,3,1},
                  '{0,4,0}, '{0,5,0}, '{0,6,0}, '{0,7,1}};
        tab_c = '{'{1,0,0}, '{1,1,0}, '{1,2,0}, '{1,3,1},
                  '{1,4,0}, '{1,5,0}, '{1,6,0}, '{1,7,1}};
        tab_d = '{'{2,0,0}, '{2,1,0}, '{2,2,0},
                  '{3,0,0}, '{3,1,0}, '{3,2,0}, '{3,3,1}};

        // Reset state, with data pending in every FIFO.
        rd_rst    = 1'b1;
        en        = 1'b1;
        ch_mask   = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) fill(i, 2);
        tick();
        sample();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_burst_abort", int'(burst_abort), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fifo_rd_en", int'(fifo_rd_en), 0);

        // A: lone channel 0 with 10 words -> bursts 4,4,2, the last ending by timeout.
        do_reset();
        ch_mask = 4'b0001;
        fill(0, 10);
        base = cap.size();
        ab0  = abort_cnt;
        en   = 1'b1;
        wait_caps(base + 10, 100);
        repeat (14) tick();
        compare_tab("A", base, tab_a);
        check("A_back_to_back", cyc_at(base + 1) - cyc_at(base), 1);
        check("A_gap1", cyc_at(base + 4) - cyc_at(base + 3), 2);
        check("A_gap2", cyc_at(base + 8) - cyc_at(base + 7), 2);
        check("A_abort_cnt", abort_cnt - ab0, 1);
        check("A_abort_delay", abort_cyc - cyc_at(base + 9), 8);
        check("A_busy_end", int'(busy), 0);

        // B: all channels loaded -> grants 0,1,2,3,0.
        do_reset();
        ch_mask = '1;
        fill(0, 8);
        fill(1, 4);
        fill(2, 4);
        fill(3, 4);
        base = cap.size();
        ab0  = abort_cnt;
        en   = 1'b1;
        wait_caps(base + 20, 150);
        repeat (4) tick();
        compare_tab("B", base, tab_b);
        check("B_abort_cnt", abort_cnt - ab0, 0);

        // C: out_ready toggling mid-burst.
        do_reset();
        ch_mask = 4'b0010;
        fill(1, 8);
        base  = cap.size();
        ab0   = abort_cnt;
        viol0 = en_viol;
        en    = 1'b1;
        for (int k = 0; k < 100 && cap.size() < base + 8; k++) begin
            tick();
            out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        repeat (12) tick();
        compare_tab("C", base, tab_c);
        check("C_pop_rule", en_viol - viol0, 0);
        check("C_abort_cnt", abort_cnt - ab0, 0);

        // D: channel 2 starves after 3 beats, channel 3 follows.
        do_reset();
        ch_mask = '1;
        fill(2, 3);
        fill(3, 4);
        base = cap.size();
        ab0  = abort_cnt;
        en   = 1'b1;
        wait_caps(base + 7, 150);
        repeat (4) tick();
        compare_tab("D", base, tab_d);
        check("D_abort_cnt", abort_cnt - ab0, 1);
        check("D_abort_delay", abort_cyc - cyc_at(base + 2), 8);
        check("D_regrant_delay", cyc_at(base + 3) - abort_cyc, 2);

        // E: en low holds everything off; raising it grants channel 0 next cycle.
        do_reset();
        ch_mask = '1;
        for (int i = 0; i < N_CH; i++) fill(i, 4);
        seen_en   = '0;
        seen_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            seen_en   = seen_en | fifo_rd_en;
            seen_busy = seen_busy | busy;
        end
        check("E_en_low_rd_en", int'(seen_en), 0);
        check("E_en_low_busy", int'(seen_busy), 0);
        tick();
        base = cap.size();
        en   = 1'b1;
        sample();
        check("E_busy_same_cycle", int'(busy), 0);
        sample();
        check("E_busy_next", int'(busy), 1);
        check("E_first_pop", int'(fifo_rd_en), 1);

        // F: asynchronous reset during channel 1's burst with a beat in the output register.
        wait_caps(base + 5, 60);
        check("F_pre_valid", int'(out_valid), 1);
        check("F_pre_ch", int'(out_ch), 1);
        #1;
        rd_rst = 1'b1;
        #1;
        check("F_rst_valid", int'(out_valid), 0);
        check("F_rst_busy", int'(busy), 0);
        check("F_rst_rd_en", int'(fifo_rd_en), 0);
        for (int i = 0; i < N_CH; i++) wr_cnt[i] = 0;
        tick();
        tick();
        rd_rst = 1'b0;
        tick();
        for (int i = 0; i < N_CH; i++) fill(i, 4);
        base = cap.size();
        wait_caps(base + 1, 40);
        check("F_restart_ch0", (base < cap.size()) ? int'(cap[base].beat) : -1,
              exp_of('{0, 0, 1'b0}));
        repeat (4) tick();

        check("pop_rule_global", en_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
